fifo_burst_reader: RTL and testbench

- Read-side controller for the async FIFO; runs entirely in the FIFO read clock domain.
- On a start pulse it drains a fixed-length burst of WIDTH-bit entries from the FIFO, honouring empty and the FIFO's 1-cycle read latency.
- It packs PACK consecutive entries into one wide word and presents each word on a valid/ready output with backpressure.
- It reports burst progress, completion and FIFO read errors.

---
 rtl/fifo_burst_reader.sv | 154 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the async FIFO: drains BURST_LEN entries, packs PACK
// consecutive entries into one output word and presents it on a valid/ready port.
module fifo_burst_reader #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PACK      = 4,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                  rd_clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  empty_i,
  output logic                  rd_en_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  rd_error_i,
  output logic [WIDTH*PACK-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      words_read_o,
  output logic [7:0]            err_cnt_o
);

  localparam int unsigned FillW = $clog2(PACK + 1);
  localparam int unsigned OutW  = WIDTH * PACK;

  typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] words_read_q, words_read_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [FillW-1:0] pending;
  logic             inflight_q, inflight_d;
  logic [OutW-1:0]  asm_q, asm_d;
  logic [OutW-1:0]  out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             out_free;
  logic             slot_ok;
  logic             rd_en;

  assign out_free = !out_valid_q || out_ready_i;
  assign pending  = fill_q + FillW'(inflight_q);

  // pending never exceeds PACK; at PACK the in-flight entry completes the current word,
  // so the next read starts a fresh word. Only the completing read needs a free output.
  assign slot_ok = (pending != FillW'(PACK - 1)) || out_free;

  assign rd_en = (state_q == StRead) && !empty_i && (remaining_q != '0) && slot_ok;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    words_read_d = words_read_q;
    fill_d       = fill_q;
    inflight_d   = rd_en;
    asm_d        = asm_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !out_ready_i;
    err_cnt_d    = err_cnt_q;

    if (rd_error_i && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    if (rd_en) begin
      remaining_d  = remaining_q - CNT_W'(1);
      words_read_d = words_read_q + CNT_W'(1);
    end

    // Read data arrives one cycle after the issue and lands in slot [fill].
    if (inflight_q) begin
      for (int unsigned s = 0; s < PACK; s++) begin
        if (fill_q == FillW'(s)) begin
          asm_d[s*WIDTH +: WIDTH] = rdata_i;
        end
      end
      if (fill_q == FillW'(PACK - 1)) begin
        out_data_d  = asm_d;
        out_valid_d = 1'b1;
        fill_d      = '0;
        asm_d       = '0;
      end else begin
        fill_d = fill_q + FillW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d      = StRead;
          remaining_d  = CNT_W'(BURST_LEN);
          words_read_d = '0;
        end
      end
      StRead: begin
        if ((remaining_q == '0) && !inflight_q) begin
          state_d = (fill_q != '0) ? StFlush : StDone;
        end
      end
      StFlush: begin
        // Unfilled upper slots are already zero: asm is cleared on every load.
        if (out_free) begin
          out_data_d  = asm_q;
          out_valid_d = 1'b1;
          fill_d      = '0;
          asm_d       = '0;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      words_read_q <= '0;
      fill_q       <= '0;
      inflight_q   <= 1'b0;
      asm_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      words_read_q <= words_read_d;
      fill_q       <= fill_d;
      inflight_q   <= inflight_d;
      asm_q        <= asm_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rd_en_o      = rd_en;
  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign words_read_o = words_read_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO and word model drive two instances
// (BURST_LEN 16 and 6) through directed bursts; outputs are checked every cycle.
module tb_fifo_burst_reader;

  localparam int unsigned W = 4;
  localparam int unsigned P = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i, empty_i, rd_error_i, out_ready_i;
  logic [W-1:0] rdata_i;
  logic         sel;  // 0: BURST_LEN=16 instance, 1: BURST_LEN=6 instance
  logic         start_a, start_b;

  logic         rd_en_a, valid_a, busy_a, done_a;
  logic [15:0]  data_a;
  logic [4:0]   wr_a;
  logic [7:0]   err_a;
  logic         rd_en_b, valid_b, busy_b, done_b;
  logic [15:0]  data_b;
  logic [2:0]   wr_b;
  logic [7:0]   err_b;

  logic         m_rd_en, m_valid, m_busy, m_done;
  logic [15:0]  m_data;
  logic [4:0]   m_wr;
  logic [7:0]   m_err;

  always #5 clk = ~clk;

  assign start_a = start_i && !sel;
  assign start_b = start_i && sel;

  fifo_burst_reader #(.WIDTH(W), .PACK(P), .BURST_LEN(16)) dut_a (
    .rd_clk_i(clk), .rst_i(rst_i), .start_i(start_a), .empty_i(empty_i), .rd_en_o(rd_en_a),
    .rdata_i(rdata_i), .rd_error_i(rd_error_i), .out_data_o(data_a), .out_valid_o(valid_a),
    .out_ready_i(out_ready_i), .busy_o(busy_a), .done_o(done_a), .words_read_o(wr_a),
    .err_cnt_o(err_a)
  );

  fifo_burst_reader #(.WIDTH(W), .PACK(P), .BURST_LEN(6)) dut_b (
    .rd_clk_i(clk), .rst_i(rst_i), .start_i(start_b), .empty_i(empty_i), .rd_en_o(rd_en_b),
    .rdata_i(rdata_i), .rd_error_i(rd_error_i), .out_data_o(data_b), .out_valid_o(valid_b),
    .out_ready_i(out_ready_i), .busy_o(busy_b), .done_o(done_b), .words_read_o(wr_b),
    .err_cnt_o(err_b)
  );

  always_comb begin
    if (sel) begin
      m_rd_en = rd_en_b; m_valid = valid_b; m_busy = busy_b; m_done = done_b;
      m_data  = data_b;  m_wr    = {2'b00, wr_b}; m_err = err_b;
    end else begin
      m_rd_en = rd_en_a; m_valid = valid_a; m_busy = busy_a; m_done = done_a;
      m_data  = data_a;  m_wr    = wr_a;          m_err = err_a;
    end
  end

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  logic [W-1:0] fifo[$];
  logic [15:0]  exp_words[$];
  logic [15:0]  got[$];
  int           issued, done_cnt, first_rd, last_rd, done_cyc, last_acc, t0;
  bit           stall = 1'b0;
  bit           pend_v = 1'b0;
  logic [W-1:0] pend_d = '0;
  bit           prev_v = 1'b0;
  bit           prev_r = 1'b0;
  logic [15:0]  prev_d = '0;
  bit           track_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    logic [15:0] w;
    if (empty_i) check("rd_en_while_empty", {31'b0, m_rd_en}, 0);
    if (prev_v && !prev_r) begin
      check("hold_valid", {31'b0, m_valid}, 1);
      check("hold_data", {16'b0, m_data}, {16'b0, prev_d});
    end
    if (m_valid && out_ready_i) begin
      vectors++;
      if (exp_words.size() == 0) begin
        miscompares++;
        $display("FAIL extra_word: got %0h, expected no word (cycle %0d)", m_data, cyc);
      end else begin
        w = exp_words.pop_front();
        check("word", {16'b0, m_data}, {16'b0, w});
      end
      got.push_back(m_data);
      last_acc = cyc;
    end
    if (track_wr) check("words_read", {27'b0, m_wr}, issued);
    if (m_done) begin
      check("busy_at_done", {31'b0, m_busy}, 1);
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_rd_en && !empty_i) begin
      issued++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
  endtask

  // One cycle: drive FIFO side mid-cycle, sample and check, then cross the rising edge.
  task automatic step();
    @(negedge clk);
    rdata_i = pend_v ? pend_d : W'(cyc);
    empty_i = stall || (fifo.size() == 0);
    #1;
    compare();
    pend_v = 1'b0;
    if (m_rd_en && !empty_i) begin
      pend_d = fifo.pop_front();
      pend_v = 1'b1;
    end
    prev_v = m_valid;
    prev_r = out_ready_i;
    prev_d = m_data;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input int n);
    fifo.delete();
    for (int i = 0; i < n; i++) fifo.push_back(W'(i));
  endtask

  task automatic start_burst(input int bl);
    logic [15:0] w;
    track_wr = 1'b0;
    exp_words.delete();
    got.delete();
    issued = 0; done_cnt = 0; first_rd = -1; last_rd = -1; done_cyc = -1; last_acc = -1;
    for (int i = 0; i < bl; i += P) begin
      w = '0;
      for (int j = 0; j < P; j++) if (i + j < bl) w[j*W +: W] = fifo[i+j];
      exp_words.push_back(w);
    end
    t0 = cyc;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    track_wr = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_words_left"}, exp_words.size(), 0);
    check({tag, "_busy_end"}, {31'b0, m_busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b1; start_i = 1'b0; empty_i = 1'b1; rd_error_i = 1'b0; out_ready_i = 1'b1;
    rdata_i = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", {31'b0, m_rd_en}, 0);
    check("rst_valid", {31'b0, m_valid}, 0);
    check("rst_data", {16'b0, m_data}, 0);
    check("rst_busy", {31'b0, m_busy}, 0);
    check("rst_done", {31'b0, m_done}, 0);
    check("rst_words_read", {27'b0, m_wr}, 0);
    check("rst_err", {24'b0, m_err}, 0);
    rst_i = 1'b0;

    // Basic drain
    load_fifo(16);
    start_burst(16);
    check("model_w0", {16'b0, exp_words[0]}, 32'h3210);
    check("model_w3", {16'b0, exp_words[3]}, 32'hFEDC);
    wait_done("basic");
    check("basic_nwords", got.size(), 4);
    if (got.size() == 4) begin
      check("basic_w0", {16'b0, got[0]}, 32'h3210);
      check("basic_w1", {16'b0, got[1]}, 32'h7654);
      check("basic_w2", {16'b0, got[2]}, 32'hBA98);
      check("basic_w3", {16'b0, got[3]}, 32'hFEDC);
    end
    check("basic_first_rd", first_rd - t0, 1);
    check("basic_last_rd", last_rd - t0, 16);
    check("basic_done_cyc", done_cyc - t0, 19);
    check("basic_words_read", {27'b0, m_wr}, 16);
    check("basic_err", {24'b0, m_err}, 0);

    // Backpressure: consumer stalled until 10 cycles after the first valid
    load_fifo(16);
    out_ready_i = 1'b0;
    start_burst(16);
    n = 0;
    while (!m_valid && n < 50) begin
      step();
      n++;
    end
    repeat (10) step();
    check("bp_issued", issued, 7);
    check("bp_valid", {31'b0, m_valid}, 1);
    check("bp_data", {16'b0, m_data}, 32'h3210);
    out_ready_i = 1'b1;
    wait_done("bp");
    check("bp_nwords", got.size(), 4);
    if (got.size() == 4) begin
      check("bp_w0", {16'b0, got[0]}, 32'h3210);
      check("bp_w3", {16'b0, got[3]}, 32'hFEDC);
    end

    // Empty stall mid-burst
    load_fifo(16);
    start_burst(16);
    n = 0;
    while (issued < 6 && n < 50) begin
      step();
      n++;
    end
    check("stall_reach", issued, 6);
    stall = 1'b1;
    repeat (5) step();
    check("stall_no_reads", issued, 6);
    stall = 1'b0;
    wait_done("stall");
    check("stall_nwords", got.size(), 4);
    if (got.size() == 4) begin
      check("stall_w1", {16'b0, got[1]}, 32'h7654);
      check("stall_w2", {16'b0, got[2]}, 32'hBA98);
    end
    check("stall_words_read", {27'b0, m_wr}, 16);

    // Partial flush on the BURST_LEN=6 instance
    sel = 1'b1;
    load_fifo(6);
    start_burst(6);
    check("model_partial", {16'b0, exp_words[1]}, 32'h0054);
    wait_done("flush");
    check("flush_nwords", got.size(), 2);
    if (got.size() == 2) begin
      check("flush_w0", {16'b0, got[0]}, 32'h3210);
      check("flush_w1", {16'b0, got[1]}, 32'h0054);
    end
    check("flush_done_cyc", done_cyc - t0, 10);
    check("flush_last_acc", last_acc, done_cyc);
    check("flush_words_read", {27'b0, m_wr}, 6);

    // Reset mid-burst after 5 reads, asserted and released between clock edges
    sel = 1'b0;
    load_fifo(16);
    start_burst(16);
    n = 0;
    while (issued < 5 && n < 50) begin
      step();
      n++;
    end
    check("rst_reach", issued, 5);
    @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_rd_en", {31'b0, m_rd_en}, 0);
    check("mid_rst_valid", {31'b0, m_valid}, 0);
    check("mid_rst_busy", {31'b0, m_busy}, 0);
    check("mid_rst_words_read", {27'b0, m_wr}, 0);
    rst_i = 1'b0;
    pend_v = 1'b0; prev_v = 1'b0; track_wr = 1'b0; issued = 0;
    for (int i = 1; i <= 5; i++) fifo.push_back(W'(i));
    start_burst(16);
    wait_done("rerun");
    check("rerun_nwords", got.size(), 4);
    if (got.size() == 4) begin
      check("rerun_w0", {16'b0, got[0]}, 32'h8765);
      check("rerun_w3", {16'b0, got[3]}, 32'h5432);
    end
    check("rerun_words_read", {27'b0, m_wr}, 16);
    check("rerun_fifo_left", fifo.size(), 0);

    // Error counter saturation
    rd_error_i = 1'b1;
    repeat (10) step();
    check("err_10", {24'b0, m_err}, 10);
    repeat (290) step();
    check("err_sat", {24'b0, m_err}, 255);
    rd_error_i = 1'b0;
    repeat (20) step();
    check("err_hold", {24'b0, m_err}, 255);
    rst_i = 1'b1;
    #1;
    check("err_rst", {24'b0, m_err}, 0);
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
